// File: rtl/gpio_port.sv
// MinX bus GPIO port: WIDTH pins with direction/data registers, input synchronisers,
// optional per-pin debounce and rising/falling edge interrupts with a write-1-to-clear status.
module gpio_port #(
   parameter int          WIDTH           = 8,
   parameter logic [23:0] BASE_ADDR       = 24'h2060,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEBOUNCE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_ce,
   input  logic             bus_write,
   input  logic             bus_read,
   input  logic [23:0]      bus_address_in,
   input  logic [7:0]       bus_data_in,
   output logic [7:0]       bus_data_out,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] pins_out,
   output logic [WIDTH-1:0] pins_oe,
   output logic             irq
);

   localparam int B    = (WIDTH + 7) / 8;
   localparam int PW   = 8 * B;
   localparam int NREG = 5;

   typedef enum int {
      REG_DIR     = 0,
      REG_DATA    = 1,
      REG_RISE_EN = 2,
      REG_FALL_EN = 3,
      REG_STATUS  = 4
   } reg_e;

   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic             irq_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] w1c_mask;
   logic [WIDTH-1:0] set_mask;
   logic [WIDTH-1:0] data_view;
   logic [PW-1:0]    rd_regs [NREG];
   logic [23:0]      offset;
   logic             in_range;
   logic             wr_en;
   logic             unused_read;

   // Reads are purely address-decoded; the strobe carries no information here.
   assign unused_read = bus_read;

   // An address below BASE_ADDR wraps to a large offset and falls out of range.
   assign offset   = bus_address_in - BASE_ADDR;
   assign in_range = (offset < 24'(NREG * B));
   assign wr_en    = clk_ce & bus_write & in_range;
   assign sync     = sync_q[SYNC_STAGES-1];

   // Overlay the addressed byte of register r onto cur; bits above WIDTH are dropped.
   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur, input int r,
                                              input logic [23:0] off, input logic [7:0] wd);
      logic [PW-1:0] pad;
      pad = PW'(cur);
      for (int k = 0; k < B; k++) begin
         if (off == 24'(r * B + k)) pad[8*k +: 8] = wd;
      end
      return pad[WIDTH-1:0];
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      dir_d     = dir_q;
      data_d    = data_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c_mask  = '0;
      if (wr_en) begin
         dir_d     = merge(dir_q,     REG_DIR,     offset, bus_data_in);
         data_d    = merge(data_q,    REG_DATA,    offset, bus_data_in);
         rise_en_d = merge(rise_en_q, REG_RISE_EN, offset, bus_data_in);
         fall_en_d = merge(fall_en_q, REG_FALL_EN, offset, bus_data_in);
         w1c_mask  = merge('0,        REG_STATUS,  offset, bus_data_in);
      end
   end

   // stable_d only differs from stable_q on clk_ce ticks, so these are tick-qualified edges.
   assign set_mask = (~stable_q & stable_d & rise_en_q) | (stable_q & ~stable_d & fall_en_q);
   // A new edge wins over a simultaneous clear of the same bit.
   assign status_d = (status_q & ~w1c_mask) | set_mask;

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
         assign stable_d = clk_ce ? sync : stable_q;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         logic [CW-1:0] cnt_q [WIDTH];
         logic [CW-1:0] cnt_d [WIDTH];

         always_comb begin
            stable_d = stable_q;
            for (int i = 0; i < WIDTH; i++) begin
               cnt_d[i] = cnt_q[i];
               if (clk_ce) begin
                  if (sync[i] == stable_q[i]) begin
                     cnt_d[i] = '0;
                  end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                     stable_d[i] = sync[i];
                     cnt_d[i]    = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            end
         end
      end
   endgenerate

   // The synchroniser runs on every clk, independent of clk_ce.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the synchroniser array is a handful of flops, not a RAM, so it is reset like any register.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pins_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_q     <= '0;
         data_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         stable_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         dir_q     <= dir_d;
         data_q    <= data_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         stable_q  <= stable_d;
         irq_q     <= |status_q;
      end
   end

   assign data_view          = (dir_q & data_q) | (~dir_q & stable_q);
   assign rd_regs[REG_DIR]     = PW'(dir_q);
   assign rd_regs[REG_DATA]    = PW'(data_view);
   assign rd_regs[REG_RISE_EN] = PW'(rise_en_q);
   assign rd_regs[REG_FALL_EN] = PW'(fall_en_q);
   assign rd_regs[REG_STATUS]  = PW'(status_q);

   always_comb begin
      bus_data_out = '0;
      if (in_range) begin
         for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < B; k++) begin
               if (offset == 24'(r * B + k)) bus_data_out = rd_regs[r][8*k +: 8];
            end
         end
      end
   end

   assign pins_oe  = dir_q;
   assign pins_out = data_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: a default instance, a debounced instance and a 12-pin debounced instance.
module tb_gpio_port;

   logic        clk;
   logic        reset_n;
   logic        clk_ce;
   logic        wr_a, wr_d, wr_w;
   logic        bus_rd;
   logic [23:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata_a, rdata_d, rdata_w;
   logic [7:0]  pins_a, pins_out_a, pins_oe_a;
   logic [7:0]  pins_d, pins_out_d, pins_oe_d;
   logic [11:0] pins_w, pins_out_w, pins_oe_w;
   logic        irq_a, irq_d, irq_w;
   int          total;
   int          bad;

   gpio_port u_a (
      .clk(clk), .reset(reset_n), .clk_ce(clk_ce), .bus_write(wr_a), .bus_read(bus_rd),
      .bus_address_in(addr), .bus_data_in(wdata), .bus_data_out(rdata_a),
      .pins_in(pins_a), .pins_out(pins_out_a), .pins_oe(pins_oe_a), .irq(irq_a));

   gpio_port #(.DEBOUNCE_CYCLES(4)) u_d (
      .clk(clk), .reset(reset_n), .clk_ce(clk_ce), .bus_write(wr_d), .bus_read(bus_rd),
      .bus_address_in(addr), .bus_data_in(wdata), .bus_data_out(rdata_d),
      .pins_in(pins_d), .pins_out(pins_out_d), .pins_oe(pins_oe_d), .irq(irq_d));

   gpio_port #(.WIDTH(12), .DEBOUNCE_CYCLES(4)) u_w (
      .clk(clk), .reset(reset_n), .clk_ce(clk_ce), .bus_write(wr_w), .bus_read(bus_rd),
      .bus_address_in(addr), .bus_data_in(wdata), .bus_data_out(rdata_w),
      .pins_in(pins_w), .pins_out(pins_out_w), .pins_oe(pins_oe_w), .irq(irq_w));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // clk_ce is high on every second rising edge; it changes just after posedge.
   initial begin
      clk_ce = 1'b0;
      forever begin
         @(posedge clk);
         #1 clk_ce = ~clk_ce;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // dut: 0 = u_a, 1 = u_d, 2 = u_w. Returns at the negedge right after the commit edge.
   task automatic wr(input int dut, input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      while (!clk_ce) @(negedge clk);
      addr  = a;
      wdata = d;
      wr_a  = (dut == 0);
      wr_d  = (dut == 1);
      wr_w  = (dut == 2);
      @(negedge clk);
      wr_a = 1'b0;
      wr_d = 1'b0;
      wr_w = 1'b0;
   endtask

   task automatic rd(input logic [23:0] a);
      addr = a;
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 'h2060; a <= 'h2065; a++) begin
         rd(24'(a));
         total++;
         if (rdata_a !== 8'h00) begin
            bad++;
            $display("FAIL reset_read_a addr=%h got=%h want=00", a, rdata_a);
         end
      end
      for (int a = 'h2060; a <= 'h206A; a++) begin
         rd(24'(a));
         total++;
         if (rdata_w !== 8'h00) begin
            bad++;
            $display("FAIL reset_read_w addr=%h got=%h want=00", a, rdata_w);
         end
      end
      total++;
      if (pins_oe_a !== 8'h00 || pins_out_a !== 8'h00 || irq_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs oe=%h out=%h irq=%b want 00/00/0", pins_oe_a, pins_out_a, irq_a);
      end
   endtask

   task automatic test_dir_data;
      wr(0, 24'h2060, 8'h0F);
      wr(0, 24'h2061, 8'hA5);
      pins_a = 8'h30;
      repeat (6) @(negedge clk);
      total++;
      if (pins_oe_a !== 8'h0F) begin
         bad++;
         $display("FAIL dir_oe got=%h want=0f", pins_oe_a);
      end
      total++;
      if (pins_out_a !== 8'hA5) begin
         bad++;
         $display("FAIL data_out got=%h want=a5", pins_out_a);
      end
      rd(24'h2061);
      total++;
      if (rdata_a !== 8'h35) begin
         bad++;
         $display("FAIL data_read got=%h want=35", rdata_a);
      end
      rd(24'h2060);
      total++;
      if (rdata_a !== 8'h0F) begin
         bad++;
         $display("FAIL dir_read got=%h want=0f", rdata_a);
      end
   endtask

   task automatic test_rise_irq;
      int  n;
      logic seen;
      wr(0, 24'h2062, 8'h01);
      rd(24'h2064);
      total++;
      if (rdata_a !== 8'h00) begin
         bad++;
         $display("FAIL status_before_edge got=%h want=00", rdata_a);
      end
      @(negedge clk);
      pins_a = 8'h31;
      n    = 0;
      seen = 1'b0;
      while (n < 4 && !seen) begin
         @(negedge clk);
         n++;
         rd(24'h2064);
         if (rdata_a === 8'h01) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL rise_status got=%h want=01 within 4 clk", rdata_a);
      end
      @(negedge clk);
      total++;
      if (irq_a !== 1'b1) begin
         bad++;
         $display("FAIL rise_irq got=%b want=1", irq_a);
      end
      wr(0, 24'h2064, 8'h01);
      rd(24'h2064);
      total++;
      if (rdata_a !== 8'h00) begin
         bad++;
         $display("FAIL w1c_status got=%h want=00", rdata_a);
      end
      total++;
      if (irq_a !== 1'b1) begin
         bad++;
         $display("FAIL w1c_irq_lag got=%b want=1", irq_a);
      end
      @(negedge clk);
      total++;
      if (irq_a !== 1'b0) begin
         bad++;
         $display("FAIL w1c_irq_drop got=%b want=0", irq_a);
      end
   endtask

   task automatic test_w1c_collision;
      pins_a = 8'h30;
      repeat (8) @(negedge clk);
      rd(24'h2064);
      total++;
      if (rdata_a !== 8'h00) begin
         bad++;
         $display("FAIL fall_not_enabled got=%h want=00", rdata_a);
      end
      // Pin set before a ce edge P0 is accepted at P2, the edge the clear commits on.
      @(negedge clk);
      while (!clk_ce) @(negedge clk);
      pins_a = 8'h31;
      @(negedge clk);
      @(negedge clk);
      addr  = 24'h2064;
      wdata = 8'h01;
      wr_a  = 1'b1;
      @(negedge clk);
      wr_a = 1'b0;
      rd(24'h2064);
      total++;
      if (rdata_a !== 8'h01) begin
         bad++;
         $display("FAIL collision_status got=%h want=01", rdata_a);
      end
   endtask

   task automatic test_debounce;
      rd(24'h2061);
      total++;
      if (rdata_d !== 8'h02) begin
         bad++;
         $display("FAIL db_settled got=%h want=02", rdata_d);
      end
      wr(1, 24'h2063, 8'h02);
      @(negedge clk);
      pins_d = 8'h00;
      repeat (6) @(negedge clk);
      pins_d = 8'h02;
      repeat (12) @(negedge clk);
      rd(24'h2064);
      total++;
      if (rdata_d !== 8'h00) begin
         bad++;
         $display("FAIL db_glitch3_status got=%h want=00", rdata_d);
      end
      rd(24'h2061);
      total++;
      if (rdata_d !== 8'h02) begin
         bad++;
         $display("FAIL db_glitch3_data got=%h want=02", rdata_d);
      end
      pins_d = 8'h00;
      repeat (8) @(negedge clk);
      pins_d = 8'h02;
      repeat (12) @(negedge clk);
      rd(24'h2064);
      total++;
      if (rdata_d !== 8'h02) begin
         bad++;
         $display("FAIL db_low4_status got=%h want=02", rdata_d);
      end
      total++;
      if (irq_d !== 1'b1) begin
         bad++;
         $display("FAIL db_low4_irq got=%b want=1", irq_d);
      end
   endtask

   task automatic test_wide;
      wr(2, 24'h2061, 8'hFF);
      total++;
      if (pins_oe_w !== 12'hF00) begin
         bad++;
         $display("FAIL wide_oe got=%h want=f00", pins_oe_w);
      end
      rd(24'h2061);
      total++;
      if (rdata_w !== 8'h0F) begin
         bad++;
         $display("FAIL wide_dir_hi got=%h want=0f", rdata_w);
      end
      rd(24'h2060);
      total++;
      if (rdata_w !== 8'h00) begin
         bad++;
         $display("FAIL wide_dir_lo got=%h want=00", rdata_w);
      end
      wr(2, 24'h2063, 8'hFF);
      total++;
      if (pins_out_w !== 12'hF00) begin
         bad++;
         $display("FAIL wide_out got=%h want=f00", pins_out_w);
      end
      rd(24'h2063);
      total++;
      if (rdata_w !== 8'h0F) begin
         bad++;
         $display("FAIL wide_data_hi got=%h want=0f", rdata_w);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      pins_w = 12'h001;
      repeat (8) @(negedge clk);
      rd(24'h2062);
      total++;
      if (rdata_w !== 8'h00) begin
         bad++;
         $display("FAIL mid_db_data got=%h want=00", rdata_w);
      end
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (pins_oe_w !== 12'h000 || pins_out_w !== 12'h000 || irq_a !== 1'b0 || irq_d !== 1'b0) begin
         bad++;
         $display("FAIL in_reset_outputs oe_w=%h out_w=%h irq_a=%b irq_d=%b want 000/000/0/0",
                  pins_oe_w, pins_out_w, irq_a, irq_d);
      end
      for (int a = 'h2060; a <= 'h2069; a++) begin
         rd(24'(a));
         total++;
         if (rdata_w !== 8'h00) begin
            bad++;
            $display("FAIL in_reset_read_w addr=%h got=%h want=00", a, rdata_w);
         end
      end
      rd(24'h2064);
      total++;
      if (rdata_a !== 8'h00) begin
         bad++;
         $display("FAIL in_reset_status_a got=%h want=00", rdata_a);
      end
      reset_n = 1'b1;
      // At most three differing ticks fit in the next seven edges, short of four.
      repeat (7) @(negedge clk);
      rd(24'h2062);
      total++;
      if (rdata_w !== 8'h00) begin
         bad++;
         $display("FAIL post_reset_counter got=%h want=00", rdata_w);
      end
      repeat (12) @(negedge clk);
      rd(24'h2062);
      total++;
      if (rdata_w !== 8'h01) begin
         bad++;
         $display("FAIL post_reset_accept got=%h want=01", rdata_w);
      end
      rd(24'h2068);
      total++;
      if (rdata_w !== 8'h00 || irq_w !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_unflagged status=%h irq=%b want=00/0", rdata_w, irq_w);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      wr_a    = 1'b0;
      wr_d    = 1'b0;
      wr_w    = 1'b0;
      bus_rd  = 1'b0;
      addr    = 24'h0;
      wdata   = 8'h00;
      pins_a  = 8'h00;
      pins_d  = 8'h00;
      pins_w  = 12'h000;
      test_reset;
      pins_d = 8'h02;
      test_dir_data;
      test_rise_irq;
      test_w1c_collision;
      test_debounce;
      test_wide;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
